// File: rtl/popcount_unary_expander.sv
`default_nettype none
// =============================================================================
// popcount_unary_expander: buffers 3-bit popcount words and re-expands each
// into a 7-bit thermometer stream, one bit per valid/ready beat.
// Revision: 1.0
// =============================================================================
module popcount_unary_expander #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               cout,
  input  logic               carry,
  input  logic               sum,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_bit,
  output logic               out_first,
  output logic               out_last,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic [FIFO_AW:0] c_full_level = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [2:0]       c_last_idx   = 3'd6;

  logic [3:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_level;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic [2:0] r_n;
  logic [2:0] w_n_nxt;
  logic       r_m;
  logic       w_m_nxt;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [3:0] w_head;

  assign w_full     = (r_level == c_full_level);
  assign w_empty    = (r_level == '0);
  assign w_push     = in_valid & ~w_full;
  assign w_head     = r_mem[r_rptr];
  assign in_ready   = ~w_full;
  assign fifo_level = r_level;
  assign busy       = (r_state == S_SHIFT) | ~w_empty;

  // Storage needs no reset: the level counter alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {in_mode, cout, carry, sum};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_AW'(1);
      end
      if (w_push & ~w_pop) begin
        r_level <= r_level + (FIFO_AW+1)'(1);
      end else if (~w_push & w_pop) begin
        r_level <= r_level - (FIFO_AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_n     <= '0;
      r_m     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_n     <= w_n_nxt;
      r_m     <= w_m_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_n_nxt     = r_n;
    w_m_nxt     = r_m;
    w_pop       = 1'b0;
    out_valid   = 1'b0;
    out_bit     = 1'b0;
    out_first   = 1'b0;
    out_last    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop                = 1'b1;
          {w_m_nxt, w_n_nxt}   = w_head;
          w_idx_nxt            = 3'd0;
          w_state_nxt          = S_SHIFT;
        end
      end
      S_SHIFT: begin
        out_valid = 1'b1;
        // Zeros-first places the N ones at the tail: bit set once idx reaches 7-N.
        out_bit   = r_m ? ({1'b0, r_idx} >= (4'd7 - {1'b0, r_n})) : (r_idx < r_n);
        out_first = (r_idx == 3'd0);
        out_last  = (r_idx == c_last_idx);
        if (out_ready) begin
          if (r_idx != c_last_idx) begin
            w_idx_nxt = r_idx + 3'd1;
          end else if (!w_empty) begin
            w_pop              = 1'b1;
            {w_m_nxt, w_n_nxt} = w_head;
            w_idx_nxt          = 3'd0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_popcount_unary_expander.sv
`default_nettype none
// =============================================================================
// tb_popcount_unary_expander: directed and randomized checks of the unary
// expander against a word-level thermometer/popcount reference model.
// Revision: 1.0
// =============================================================================
module tb_popcount_unary_expander;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       cout;
  logic       carry;
  logic       sum;
  logic       in_mode;
  logic       out_valid;
  logic       out_ready;
  logic       out_bit;
  logic       out_first;
  logic       out_last;
  logic [2:0] fifo_level;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0] n;
    logic       m;
  } word_t;

  word_t exp_q[$];

  popcount_unary_expander #(
    .FIFO_DEPTH(4),
    .FIFO_AW   (2)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cout      (cout),
    .carry     (carry),
    .sum       (sum),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last),
    .fifo_level(fifo_level),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Thermometer of N ones, anchored at bit 0 (mode 0) or bit 6 (mode 1).
  function automatic logic [6:0] exp_pattern(input word_t w);
    logic [6:0] all_ones;
    all_ones = 7'h7f;
    if (w.m) return all_ones << (7 - int'(w.n));
    return ~(all_ones << int'(w.n));
  endfunction

  function automatic logic [2:0] compress7to3(input logic [6:0] b);
    int c;
    c = 0;
    for (int i = 0; i < 7; i++) c += int'(b[i]);
    return 3'(c);
  endfunction

  // Output monitor: samples on the falling edge, between driver updates.
  initial begin : mon
    int         bitpos;
    logic [6:0] got_bits;
    logic [6:0] pat;
    logic       prev_stall, prev_bit, prev_first, prev_last;
    word_t      w;
    bitpos     = 0;
    got_bits   = '0;
    prev_stall = 1'b0;
    prev_bit   = 1'b0;
    prev_first = 1'b0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        bitpos     = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_bit",   32'(out_bit),   32'(prev_bit));
          check("stall_first", 32'(out_first), 32'(prev_first));
          check("stall_last",  32'(out_last),  32'(prev_last));
        end
        prev_stall = out_valid & ~out_ready;
        prev_bit   = out_bit;
        prev_first = out_first;
        prev_last  = out_last;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 32'(out_valid), 32'd0);
          end else begin
            w   = exp_q[0];
            pat = exp_pattern(w);
            check("out_bit",   32'(out_bit),   32'(pat[bitpos]));
            check("out_first", 32'(out_first), 32'(bitpos == 0));
            check("out_last",  32'(out_last),  32'(bitpos == 6));
            got_bits[bitpos] = out_bit;
            bitpos++;
            if (bitpos == 7) begin
              check("roundtrip", 32'(compress7to3(got_bits)), 32'(w.n));
              void'(exp_q.pop_front());
              bitpos = 0;
            end
          end
        end
        if (in_valid && in_ready) begin
          w.n = {cout, carry, sum};
          w.m = in_mode;
          exp_q.push_back(w);
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic push_word(input logic [2:0] n, input logic m);
    int g;
    @(posedge clk);
    #1;
    in_valid            = 1'b1;
    {cout, carry, sum}  = n;
    in_mode             = m;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("push_timeout", 32'(g), 32'd0);
  endtask

  task automatic idle_in();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || out_valid) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check(tag, 32'(g < 2000), 32'd1);
    check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    int w;
    int g;
    int sent;
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    cout      = 1'b0;
    carry     = 1'b0;
    sum       = 1'b0;
    in_mode   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level",     32'(fifo_level), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_bits",  32'({out_bit, out_first, out_last}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // N=3 ones-first, first-bit latency
    push_word(3'd3, 1'b0);
    check("lat_t0_valid", 32'(out_valid), 32'd0);
    idle_in();
    @(negedge clk);
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    check("lat_t1_level", 32'(fifo_level), 32'd1);
    check("lat_t1_busy",  32'(busy), 32'd1);
    @(negedge clk);
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    check("lat_t2_first", 32'(out_first), 32'd1);
    repeat (7) @(negedge clk);
    check("idle_after_valid", 32'(out_valid), 32'd0);
    check("idle_after_busy",  32'(busy), 32'd0);

    // N=5 zeros-first
    push_word(3'd5, 1'b1);
    idle_in();
    drain("drain_n5");

    // N=0 then N=7, back to back
    push_word(3'd0, 1'b0);
    push_word(3'd7, 1'b1);
    idle_in();
    g = 0;
    @(negedge clk);
    while (!out_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    for (int k = 0; k < 14; k++) begin
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_first", 32'(out_first), 32'(k == 0 || k == 7));
      @(negedge clk);
    end
    check("b2b_end_valid", 32'(out_valid), 32'd0);

    // Full FIFO under backpressure
    @(posedge clk);
    #1 out_ready = 1'b0;
    push_word(3'd3, 1'b0);
    push_word(3'd5, 1'b1);
    push_word(3'd0, 1'b0);
    push_word(3'd7, 1'b1);
    push_word(3'd1, 1'b0);
    @(posedge clk);
    #1;
    in_valid           = 1'b1;
    {cout, carry, sum} = 3'd6;
    in_mode            = 1'b1;
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level",    32'(fifo_level), 32'd4);
    check("full_valid",    32'(out_valid), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    check("full_release_cycles", 32'(w), 32'd7);
    check("full_release_level",  32'(fifo_level), 32'd3);
    idle_in();
    drain("drain_full");

    // Random words under random backpressure
    sent = 0;
    g    = 0;
    acc  = 1'b0;
    while (sent < 1000 && g < 60000) begin
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
      acc       = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 2) != 0) begin
        in_valid           = 1'b1;
        {cout, carry, sum} = 3'($urandom_range(0, 7));
        in_mode            = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc = 1'b1;
        sent++;
      end
      g++;
    end
    check("rand_sent", 32'(sent), 32'd1000);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("drain_rand");

    // Reset mid-word: N=6 at idx 3 with two words buffered
    @(posedge clk);
    #1 out_ready = 1'b0;
    push_word(3'd6, 1'b0);
    push_word(3'd1, 1'b1);
    push_word(3'd4, 1'b0);
    idle_in();
    @(negedge clk);
    check("mid_level",  32'(fifo_level), 32'd2);
    check("mid_first",  32'(out_first), 32'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    push_word(3'd2, 1'b0);
    idle_in();
    drain("drain_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
